conv_layer_sequencer: RTL and testbench

Sequences one conv2d 3x3 engine over a full layer of N_OUT_CH output channels from one single-channel input feature map.
For each channel it does four things in order:
- loads 9 weights plus bias from weight memory into held registers;
- clears the engine's internal counters;
- streams the frame from feature memory;
- writes the engine's (W-2)*(H-2) outputs to output memory.
It sits between the layer-level control (start/done) and the engine plus its three memories.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_weight_loader.sv | 79 +++++++
 rtl/conv_layer_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv2d layer sequencer: FSM state encoding,
// per-channel weight count and frame/output pixel counts.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        CLR    = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int WEIGHTS_PER_CH = 10;
    localparam int DEF_IMG_WIDTH  = 16;
    localparam int DEF_IMG_HEIGHT = 16;
    localparam int FRAME_PIX      = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
    localparam int OUT_PIX        = (DEF_IMG_WIDTH - 2) * (DEF_IMG_HEIGHT - 2);

    function automatic int frame_pix(input int w, input int h);
        return w * h;
    endfunction

    function automatic int out_pix(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/conv_weight_loader.sv
// Reads one channel's 9 weights plus bias from weight memory and holds them
// for the engine; captures are delayed one cycle to match the memory latency.
module conv_weight_loader
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base,
    output logic                    w_rd_en,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0]   w_rdata,
    output logic [9*DATA_WIDTH-1:0] eng_w,
    output logic [DATA_WIDTH-1:0]   eng_bias,
    output logic                    load_done
);

    localparam int KW = $clog2(WEIGHTS_PER_CH);

    logic [KW-1:0]         rd_cnt_r;
    logic [KW-1:0]         cap_idx_r;
    logic                  rd_en_r;
    logic                  cap_en_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [DATA_WIDTH-1:0] w_r [0:WEIGHTS_PER_CH-1];

    // Read issue counter and one-cycle-delayed capture into the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r  <= {KW{1'b0}};
            cap_idx_r <= {KW{1'b0}};
            rd_en_r   <= 1'b0;
            cap_en_r  <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            for (int i = 0; i < WEIGHTS_PER_CH; i++) begin
                w_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            cap_en_r  <= rd_en_r;
            cap_idx_r <= rd_cnt_r;
            if (start) begin
                rd_en_r  <= 1'b1;
                rd_cnt_r <= {KW{1'b0}};
                addr_r   <= base;
            end else if (rd_en_r) begin
                if (rd_cnt_r == KW'(WEIGHTS_PER_CH - 1)) begin
                    rd_en_r  <= 1'b0;
                    rd_cnt_r <= {KW{1'b0}};
                    addr_r   <= {ADDR_W{1'b0}};
                end else begin
                    rd_cnt_r <= rd_cnt_r + 1'b1;
                    addr_r   <= addr_r + 1'b1;
                end
            end else begin
                rd_en_r <= 1'b0;
            end
            if (cap_en_r) begin
                w_r[cap_idx_r] <= w_rdata;
            end
        end
    end

    // Pack w0..w8 LSB-first onto the engine weight bus
    always_comb begin
        eng_w = {(9*DATA_WIDTH){1'b0}};
        for (int i = 0; i < 9; i++) begin
            eng_w[i*DATA_WIDTH +: DATA_WIDTH] = w_r[i];
        end
    end

    assign eng_bias  = w_r[WEIGHTS_PER_CH-1];
    assign w_rd_en   = rd_en_r;
    assign w_addr    = addr_r;
    assign load_done = cap_en_r && (cap_idx_r == KW'(WEIGHTS_PER_CH - 1));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs one conv2d 3x3 engine over every output channel of a layer: load weights,
// clear engine, stream the frame, collect outputs into output memory.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int DATA_WIDTH = 16,
    parameter int N_OUT_CH   = 4,
    parameter int ADDR_W     = 12,
    parameter int DRAIN_MAX  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    w_rd_en,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0]   w_rdata,
    output logic                    f_rd_en,
    output logic [ADDR_W-1:0]       f_addr,
    input  logic [DATA_WIDTH-1:0]   f_rdata,
    output logic                    eng_rst_n,
    output logic                    eng_valid_in,
    output logic [DATA_WIDTH-1:0]   eng_data_in,
    output logic [9*DATA_WIDTH-1:0] eng_w,
    output logic [DATA_WIDTH-1:0]   eng_bias,
    input  logic                    eng_valid_out,
    input  logic [DATA_WIDTH-1:0]   eng_data_out,
    output logic                    o_wr_en,
    output logic [ADDR_W-1:0]       o_addr,
    output logic [DATA_WIDTH-1:0]   o_wdata
);

    localparam int FRAME_N = frame_pix(IMG_WIDTH, IMG_HEIGHT);
    localparam int OUT_N   = out_pix(IMG_WIDTH, IMG_HEIGHT);
    localparam int CH_W    = (N_OUT_CH > 1) ? $clog2(N_OUT_CH) : 1;
    localparam int PIX_W   = $clog2(FRAME_N);
    localparam int OUT_W   = $clog2(OUT_N + 1);
    localparam int DRN_W   = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    state_t                state_r, state_nxt_s;
    logic [CH_W-1:0]       ch_r, ch_nxt_s;
    logic [OUT_W-1:0]      out_cnt_r;
    logic [PIX_W-1:0]      pix_cnt_r;
    logic [DRN_W-1:0]      drain_cnt_r;
    logic                  f_rd_en_r, rd_pend_r, eng_valid_in_r;
    logic [DATA_WIDTH-1:0] eng_data_in_r;
    logic                  busy_r, done_r, err_r, eng_rst_n_r;
    logic                  load_start_s, load_done_s, capture_s, stream_last_s;
    logic [ADDR_W-1:0]     w_base_s;

    assign capture_s     = eng_valid_out && ((state_r == STREAM) || (state_r == DRAIN));
    // Last pixel is on the engine bus and nothing is left in the read pipe
    assign stream_last_s = eng_valid_in_r && !rd_pend_r && !f_rd_en_r;
    assign load_start_s  = (state_nxt_s == LOAD_W) && (state_r != LOAD_W);
    assign w_base_s      = ADDR_W'(32'(ch_nxt_s) * 32'(WEIGHTS_PER_CH));

    // Next-state and channel index selection
    always_comb begin
        state_nxt_s = state_r;
        ch_nxt_s    = ch_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD_W;
                    ch_nxt_s    = {CH_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_W: begin
                if (load_done_s) state_nxt_s = CLR;
                else             state_nxt_s = LOAD_W;
            end
            CLR:    state_nxt_s = STREAM;
            STREAM: begin
                if (stream_last_s) state_nxt_s = DRAIN;
                else               state_nxt_s = STREAM;
            end
            DRAIN: begin
                if (out_cnt_r == OUT_W'(OUT_N))                  state_nxt_s = NEXT;
                else if (drain_cnt_r == DRN_W'(DRAIN_MAX - 1))   state_nxt_s = DONE;
                else                                             state_nxt_s = DRAIN;
            end
            NEXT: begin
                if (ch_r == CH_W'(N_OUT_CH - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = LOAD_W;
                    ch_nxt_s    = ch_r + 1'b1;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, channel and registered status/control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ch_r        <= {CH_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            eng_rst_n_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            ch_r        <= ch_nxt_s;
            busy_r      <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
            done_r      <= (state_nxt_s == DONE);
            eng_rst_n_r <= (state_nxt_s != CLR);
            if ((state_r == IDLE) && start) begin
                err_r <= 1'b0;
            end else if ((state_r == DRAIN) && (state_nxt_s == DONE)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Output counter and drain timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_r   <= {OUT_W{1'b0}};
            drain_cnt_r <= {DRN_W{1'b0}};
        end else begin
            if (load_start_s)   out_cnt_r <= {OUT_W{1'b0}};
            else if (capture_s) out_cnt_r <= out_cnt_r + 1'b1;
            else                out_cnt_r <= out_cnt_r;
            if (state_r == DRAIN) drain_cnt_r <= drain_cnt_r + 1'b1;
            else                  drain_cnt_r <= {DRN_W{1'b0}};
        end
    end

    // Raster read burst and alignment of memory data onto the engine input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rd_en_r      <= 1'b0;
            pix_cnt_r      <= {PIX_W{1'b0}};
            rd_pend_r      <= 1'b0;
            eng_valid_in_r <= 1'b0;
            eng_data_in_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            if (state_r == CLR) begin
                f_rd_en_r <= 1'b1;
                pix_cnt_r <= {PIX_W{1'b0}};
            end else if (f_rd_en_r) begin
                if (pix_cnt_r == PIX_W'(FRAME_N - 1)) begin
                    f_rd_en_r <= 1'b0;
                    pix_cnt_r <= {PIX_W{1'b0}};
                end else begin
                    pix_cnt_r <= pix_cnt_r + 1'b1;
                end
            end else begin
                f_rd_en_r <= 1'b0;
            end
            rd_pend_r      <= f_rd_en_r;
            eng_valid_in_r <= rd_pend_r;
            eng_data_in_r  <= rd_pend_r ? f_rdata : {DATA_WIDTH{1'b0}};
        end
    end

    // Output memory write path follows the engine valid in the same cycle
    always_comb begin
        if (capture_s) begin
            o_wr_en = 1'b1;
            o_addr  = ADDR_W'(32'(ch_r) * 32'(OUT_N) + 32'(out_cnt_r));
            o_wdata = eng_data_out;
        end else begin
            o_wr_en = 1'b0;
            o_addr  = {ADDR_W{1'b0}};
            o_wdata = {DATA_WIDTH{1'b0}};
        end
    end

    conv_weight_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (load_start_s),
        .base      (w_base_s),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .eng_w     (eng_w),
        .eng_bias  (eng_bias),
        .load_done (load_done_s)
    );

    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign f_rd_en      = f_rd_en_r;
    assign f_addr       = ADDR_W'(pix_cnt_r) & {ADDR_W{f_rd_en_r}};
    assign eng_rst_n    = eng_rst_n_r;
    assign eng_valid_in = eng_valid_in_r;
    assign eng_data_in  = eng_data_in_r;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer on a 4x4 frame, two channels, with
// behavioural weight/feature memories and a small conv2d 3x3 engine (Q8.8).
module tb_conv_layer_sequencer;

    localparam int DW  = 16;
    localparam int AW  = 12;
    localparam int DMX = 20;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, err, w_rd_en, f_rd_en, eng_rst_n, eng_valid_in, o_wr_en;
    logic [AW-1:0]   w_addr, f_addr, o_addr;
    logic [DW-1:0]   w_rdata, f_rdata, eng_data_in, eng_bias, o_wdata, eng_data_out;
    logic [9*DW-1:0] eng_w;
    logic            eng_valid_out;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]        wmem [0:31];
    logic [DW-1:0]        fmem [0:15];
    logic signed [DW-1:0] pix  [0:15];
    logic                 kill = 1'b0;
    int                   e_cnt, e_outs;

    int              cyc = 0, done_cnt = 0, clr_cnt = 0, order_bad = 0, last_vin_cyc = 0, done_cyc = 0;
    logic            clr_prev = 1'b0;
    logic [AW-1:0]   wr_addr_q [$];
    logic [DW-1:0]   wr_data_q [$];
    logic [9*DW-1:0] wr_w_q [$];
    logic [9*DW-1:0] snap_w_q [$];
    logic [DW-1:0]   snap_b_q [$];

    conv_layer_sequencer #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_WIDTH(DW),
        .N_OUT_CH(2), .ADDR_W(AW), .DRAIN_MAX(DMX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .f_rd_en(f_rd_en), .f_addr(f_addr), .f_rdata(f_rdata),
        .eng_rst_n(eng_rst_n), .eng_valid_in(eng_valid_in), .eng_data_in(eng_data_in),
        .eng_w(eng_w), .eng_bias(eng_bias),
        .eng_valid_out(eng_valid_out), .eng_data_out(eng_data_out),
        .o_wr_en(o_wr_en), .o_addr(o_addr), .o_wdata(o_wdata)
    );

    always #5 clk = ~clk;

    // Memories with one-cycle read latency
    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= wmem[w_addr[4:0]];
        if (f_rd_en) f_rdata <= fmem[f_addr[3:0]];
    end

    function automatic logic [DW-1:0] conv_at(input int n, input logic [DW-1:0] cur);
        int acc, idx;
        logic signed [DW-1:0] p, w;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            idx = n - (2 - i / 3) * 4 - (2 - i % 3);
            p   = (i == 8) ? $signed(cur) : pix[idx];
            w   = $signed(eng_w[i*DW +: DW]);
            acc = acc + p * w;
        end
        return DW'((acc >>> 8) + int'($signed(eng_bias)));
    endfunction

    // Engine model: counters cleared by eng_rst_n, one output per full window
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt <= 0; e_outs <= 0; eng_valid_out <= 1'b0; eng_data_out <= 16'd0;
        end else if (!eng_rst_n) begin
            e_cnt <= 0; e_outs <= 0; eng_valid_out <= 1'b0;
        end else begin
            eng_valid_out <= 1'b0;
            if (eng_valid_in) begin
                pix[e_cnt] <= eng_data_in;
                e_cnt <= e_cnt + 1;
                if ((e_cnt / 4) >= 2 && (e_cnt % 4) >= 2 && !(kill && e_outs >= 2)) begin
                    eng_valid_out <= 1'b1;
                    eng_data_out  <= conv_at(e_cnt, eng_data_in);
                    e_outs        <= e_outs + 1;
                end
            end
        end
    end

    // Observation log sampled on the falling edge
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        clr_prev <= !eng_rst_n;
        if (o_wr_en) begin
            wr_addr_q.push_back(o_addr);
            wr_data_q.push_back(o_wdata);
            wr_w_q.push_back(eng_w);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (!eng_rst_n) clr_cnt <= clr_cnt + 1;
        if (f_rd_en && f_addr == 12'd0) begin
            snap_w_q.push_back(eng_w);
            snap_b_q.push_back(eng_bias);
            if (!clr_prev) order_bad <= order_bad + 1;
        end
        if (eng_valid_in) last_vin_cyc <= cyc;
    end

    task automatic set_identity(input logic [DW-1:0] bias1);
        for (int i = 0; i < 32; i++) wmem[i] = 16'd0;
        wmem[4]  = 16'd256;
        wmem[14] = 16'd256;
        wmem[19] = bias1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout got no done within 1000 cycles want done pulse", tag);
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, w_rd_en, f_rd_en, eng_rst_n, eng_valid_in, o_wr_en} !== 8'b0000_0100) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000100",
                     {busy, done, err, w_rd_en, f_rd_en, eng_rst_n, eng_valid_in, o_wr_en});
        end
        checks++;
        if (eng_w !== 144'd0 || eng_bias !== 16'd0) begin
            errors++;
            $display("FAIL reset_weights got w=%h b=%h want 0", eng_w, eng_bias);
        end
        checks++;
        if (w_addr !== 12'd0 || f_addr !== 12'd0 || o_addr !== 12'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d/%0d/%0d want 0/0/0", w_addr, f_addr, o_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_layer(input string tag, input int wb);
        int exp_d [8];
        exp_d = '{6, 7, 10, 11, 262, 263, 266, 267};
        checks++;
        if (wr_addr_q.size() - wb !== 8) begin
            errors++;
            $display("FAIL %s_wr_count got %0d want 8", tag, wr_addr_q.size() - wb);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_addr_q[wb+i] !== AW'(i) || wr_data_q[wb+i] !== DW'(exp_d[i])) begin
                    errors++;
                    $display("FAIL %s_wr%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                             tag, i, wr_addr_q[wb+i], wr_data_q[wb+i], i, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_layer();
        int wb, db, cb, ob;
        set_identity(16'd256);
        wb = wr_addr_q.size(); db = done_cnt; cb = clr_cnt; ob = order_bad;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || w_rd_en !== 1'b1 || w_addr !== 12'd0) begin
            errors++;
            $display("FAIL layer_first_read got busy=%b rd=%b addr=%0d want 1 1 0", busy, w_rd_en, w_addr);
        end
        wait_done("layer");
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL layer_done_flags got busy=%b err=%b want 0 0", busy, err);
        end
        settle();
        check_layer("layer", wb);
        checks++;
        if (done_cnt - db !== 1) begin
            errors++;
            $display("FAIL layer_done_count got %0d want 1", done_cnt - db);
        end
        checks++;
        if (clr_cnt - cb !== 2 || order_bad !== ob) begin
            errors++;
            $display("FAIL layer_eng_clr got lows=%0d misordered=%0d want 2 0", clr_cnt - cb, order_bad - ob);
        end
    endtask

    task automatic test_weight_order();
        int sb, wb;
        logic [9*DW-1:0] exp0, exp1;
        for (int i = 0; i < 32; i++) wmem[i] = DW'(i);
        for (int i = 0; i < 9; i++) begin
            exp0[i*DW +: DW] = DW'(i);
            exp1[i*DW +: DW] = DW'(10 + i);
        end
        sb = snap_w_q.size(); wb = wr_w_q.size();
        pulse_start();
        wait_done("worder");
        settle();
        checks++;
        if (snap_w_q.size() - sb !== 2) begin
            errors++;
            $display("FAIL worder_snaps got %0d want 2", snap_w_q.size() - sb);
        end else begin
            checks++;
            if (snap_w_q[sb] !== exp0 || snap_b_q[sb] !== 16'd9) begin
                errors++;
                $display("FAIL worder_ch0 got w=%h b=%0d want w=%h b=9", snap_w_q[sb], snap_b_q[sb], exp0);
            end
            checks++;
            if (snap_w_q[sb+1] !== exp1 || snap_b_q[sb+1] !== 16'd19) begin
                errors++;
                $display("FAIL worder_ch1 got w=%h b=%0d want w=%h b=19", snap_w_q[sb+1], snap_b_q[sb+1], exp1);
            end
        end
        checks++;
        if (wr_w_q.size() - wb !== 8) begin
            errors++;
            $display("FAIL worder_wr_count got %0d want 8", wr_w_q.size() - wb);
        end else begin
            checks++;
            if (wr_w_q[wb+3] !== exp0 || wr_w_q[wb+7] !== exp1) begin
                errors++;
                $display("FAIL worder_stable got %h / %h want %h / %h", wr_w_q[wb+3], wr_w_q[wb+7], exp0, exp1);
            end
        end
    endtask

    task automatic test_timeout();
        int wb, db;
        set_identity(16'd256);
        kill = 1'b1;
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        wait_done("timeout");
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags got err=%b busy=%b want 1 0", err, busy);
        end
        settle();
        kill = 1'b0;
        checks++;
        if (done_cyc - last_vin_cyc !== DMX + 1) begin
            errors++;
            $display("FAIL timeout_latency got %0d want %0d", done_cyc - last_vin_cyc, DMX + 1);
        end
        checks++;
        if (wr_addr_q.size() - wb !== 2 || done_cnt - db !== 1) begin
            errors++;
            $display("FAIL timeout_counts got writes=%0d dones=%0d want 2 1", wr_addr_q.size() - wb, done_cnt - db);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got err=%b want 1", err);
        end
    endtask

    task automatic test_start_ignored();
        int wb, db;
        bit seen;
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_err got err=%b want 0", err);
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (f_rd_en) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ignore_stream_wait got no f_rd_en want stream");
        end
        pulse_start();
        wait_done("ignore");
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || w_rd_en !== 1'b0 || done_cnt - db !== 1) begin
            errors++;
            $display("FAIL ignore_single_run got busy=%b rd=%b dones=%0d want 0 0 1", busy, w_rd_en, done_cnt - db);
        end
        check_layer("ignore", wb);
    endtask

    task automatic test_reset_mid_stream();
        int wb, db;
        bit seen;
        db = done_cnt;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (f_rd_en && f_addr == 12'd5) seen = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || {busy, done, err, w_rd_en, f_rd_en, eng_rst_n, eng_valid_in, o_wr_en} !== 8'b0000_0100) begin
            errors++;
            $display("FAIL midrst_ctrl got seen=%b ctrl=%b want 1 00000100", seen,
                     {busy, done, err, w_rd_en, f_rd_en, eng_rst_n, eng_valid_in, o_wr_en});
        end
        checks++;
        if (eng_w !== 144'd0 || eng_bias !== 16'd0 || f_addr !== 12'd0) begin
            errors++;
            $display("FAIL midrst_regs got w=%h b=%0d faddr=%0d want 0", eng_w, eng_bias, f_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done_cnt !== db) begin
            errors++;
            $display("FAIL midrst_no_done got %0d want 0", done_cnt - db);
        end
        wb = wr_addr_q.size();
        pulse_start();
        wait_done("midrst");
        settle();
        check_layer("midrst", wb);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) fmem[i] = DW'(i + 1);
        test_reset();
        test_layer();
        test_weight_order();
        test_timeout();
        test_start_ignored();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
